// File: rtl/game_sequencer_if.sv
// game_sequencer_if
//   Groups the signals exchanged between the breakout game sequencer and
//   the game datapath (painters, block_state, ball/paddle logic).
//   master : the sequencer. It consumes frame/datapath events and the select
//            button, and drives the phase and control outputs.
//   slave  : the datapath/top-level side. It mirrors the master.
//   Signals:
//     frame_pulse  one-cycle pulse per video frame
//     btn_select   raw asynchronous select button
//     ball_lost    level, ball passed below the paddle
//     block_hit    one-cycle pulse per destroyed block
//     blocks_empty level, no blocks remain
//     state        game phase (ATTRACT=0 .. GAMEOVER=5)
//     ball_hold / ball_freeze / ball_launch / paddle_en / blocks_reload
//     lives, level, score_bcd (three BCD digits)
interface game_sequencer_if;
  logic        frame_pulse;
  logic        btn_select;
  logic        ball_lost;
  logic        block_hit;
  logic        blocks_empty;
  logic [2:0]  state;
  logic        ball_hold;
  logic        ball_freeze;
  logic        ball_launch;
  logic        paddle_en;
  logic        blocks_reload;
  logic [1:0]  lives;
  logic [2:0]  level;
  logic [11:0] score_bcd;

  modport master (
    input  frame_pulse, btn_select, ball_lost, block_hit, blocks_empty,
    output state, ball_hold, ball_freeze, ball_launch, paddle_en,
           blocks_reload, lives, level, score_bcd
  );

  modport slave (
    output frame_pulse, btn_select, ball_lost, block_hit, blocks_empty,
    input  state, ball_hold, ball_freeze, ball_launch, paddle_en,
           blocks_reload, lives, level, score_bcd
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer
//   Top-level breakout phase controller. It walks through the ATTRACT,
//   SERVE, PLAY, LOST, CLEARED and GAMEOVER phases. It owns lives, level
//   and a saturating three-digit BCD score, and it issues ball hold,
//   freeze and launch, paddle enable, and block-field reload controls.
//   All outputs are registered.
//   Ports:
//     clk   system clock
//     nRst  asynchronous active-low reset
//     bus   game_sequencer_if.master (events in, controls/status out)
module game_sequencer #(
  parameter int START_LIVES  = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 90
) (
  input  logic              clk,
  input  logic              nRst,
  game_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_ATTRACT  = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_LOST     = 3'd3,
    ST_CLEARED  = 3'd4,
    ST_GAMEOVER = 3'd5
  } state_t;

  localparam int MAX_FRAMES = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES + 1);

  // Increments a 3-digit BCD value with decimal carry and saturates at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v == 12'h999) begin
      r = v;
    end else if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic          sync_meta_r;
  logic          sync_r;
  logic          sync_prev_r;
  logic          sel_edge_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    lives_r;
  logic [2:0]    level_r;
  logic [11:0]   score_r;
  logic          hold_r;
  logic          freeze_r;
  logic          launch_r;
  logic          paddle_r;
  logic          reload_r;

  logic          new_game_s;
  logic          level_up_s;
  logic          lose_life_s;
  logic          serve_done_s;
  logic          pause_done_s;
  logic          hit_s;
  logic          hold_nxt_s;
  logic          freeze_nxt_s;
  logic          paddle_nxt_s;
  logic          launch_nxt_s;
  logic          reload_nxt_s;

  // A timed phase ends on the frame pulse that brings the count to its limit.
  assign serve_done_s = bus.frame_pulse && (cnt_r == CW'(SERVE_FRAMES - 1));
  assign pause_done_s = bus.frame_pulse && (cnt_r == CW'(PAUSE_FRAMES - 1));
  // A hit is scored whenever the current phase is PLAY, including the exit cycle.
  assign hit_s        = bus.block_hit && (state_r == ST_PLAY);

  // Select button: two-flop synchronizer, then a registered rising-edge detector.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
      sync_prev_r <= 1'b0;
      sel_edge_r  <= 1'b0;
    end else begin
      sync_meta_r <= bus.btn_select;
      sync_r      <= sync_meta_r;
      sync_prev_r <= sync_r;
      sel_edge_r  <= sync_r & ~sync_prev_r;
    end
  end

  // Phase state register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_r <= ST_ATTRACT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-phase decision and the one-shot datapath actions tied to each transition.
  always_comb begin
    state_nxt_s = state_r;
    new_game_s  = 1'b0;
    level_up_s  = 1'b0;
    lose_life_s = 1'b0;
    case (state_r)
      ST_ATTRACT, ST_GAMEOVER: begin
        if (sel_edge_r) begin
          state_nxt_s = ST_SERVE;
          new_game_s  = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_SERVE: begin
        if (sel_edge_r || serve_done_s) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      ST_PLAY: begin
        // Clearing the field wins over losing the ball in the same cycle.
        if (bus.blocks_empty) begin
          state_nxt_s = ST_CLEARED;
        end else if (bus.ball_lost) begin
          state_nxt_s = ST_LOST;
          lose_life_s = 1'b1;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_LOST: begin
        if (pause_done_s) begin
          if (lives_r == 2'd0) begin
            state_nxt_s = ST_GAMEOVER;
          end else begin
            state_nxt_s = ST_SERVE;
          end
        end else begin
          state_nxt_s = ST_LOST;
        end
      end
      ST_CLEARED: begin
        if (pause_done_s) begin
          state_nxt_s = ST_SERVE;
          level_up_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CLEARED;
        end
      end
      default: begin
        // Unused encodings 6 and 7 recover to ATTRACT.
        state_nxt_s = ST_ATTRACT;
      end
    endcase
  end

  // Next values of the phase-decoded controls, registered alongside the state.
  always_comb begin
    hold_nxt_s   = 1'b0;
    freeze_nxt_s = 1'b0;
    paddle_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_SERVE: begin
        hold_nxt_s   = 1'b1;
        paddle_nxt_s = 1'b1;
      end
      ST_PLAY: begin
        paddle_nxt_s = 1'b1;
      end
      default: begin
        freeze_nxt_s = 1'b1;
      end
    endcase
    launch_nxt_s = (state_r == ST_SERVE) && (state_nxt_s == ST_PLAY);
    reload_nxt_s = new_game_s | level_up_s;
  end

  // Registered control outputs; the pulses line up with the first cycle of the new phase.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hold_r   <= 1'b0;
      freeze_r <= 1'b1;
      paddle_r <= 1'b0;
      launch_r <= 1'b0;
      reload_r <= 1'b0;
    end else begin
      hold_r   <= hold_nxt_s;
      freeze_r <= freeze_nxt_s;
      paddle_r <= paddle_nxt_s;
      launch_r <= launch_nxt_s;
      reload_r <= reload_nxt_s;
    end
  end

  // Frame counter: restarts on every phase change and saturates instead of wrapping.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_r <= '0;
    end else if (state_nxt_s != state_r) begin
      cnt_r <= '0;
    end else if (bus.frame_pulse && (cnt_r != CW'(MAX_FRAMES))) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Lives: reloaded on a new game, decremented on entry to LOST.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      lives_r <= 2'(START_LIVES);
    end else if (new_game_s) begin
      lives_r <= 2'(START_LIVES);
    end else if (lose_life_s && (lives_r != 2'd0)) begin
      lives_r <= lives_r - 2'd1;
    end else begin
      lives_r <= lives_r;
    end
  end

  // Level: cleared on a new game, advanced (saturating at 7) when leaving CLEARED.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      level_r <= 3'd0;
    end else if (new_game_s) begin
      level_r <= 3'd0;
    end else if (level_up_s && (level_r != 3'd7)) begin
      level_r <= level_r + 3'd1;
    end else begin
      level_r <= level_r;
    end
  end

  // Score: cleared on a new game, otherwise held (including through GAMEOVER) except on hits.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      score_r <= 12'h000;
    end else if (new_game_s) begin
      score_r <= 12'h000;
    end else if (hit_s) begin
      score_r <= bcd_inc(score_r);
    end else begin
      score_r <= score_r;
    end
  end

  assign bus.state         = state_r;
  assign bus.ball_hold     = hold_r;
  assign bus.ball_freeze   = freeze_r;
  assign bus.ball_launch   = launch_r;
  assign bus.paddle_en     = paddle_r;
  assign bus.blocks_reload = reload_r;
  assign bus.lives         = lives_r;
  assign bus.level         = level_r;
  assign bus.score_bcd     = score_r;

endmodule
